ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Synchronous FIFO controller that turns the 64x8 asynchronous dual-port RAM into a first-in/first-out buffer. Producers push words through a valid/full interface and consumers pop through a request/valid interface. The controller drives RAM port A as the write port and port B as the read port, and owns all pointer, occupancy and flag logic. It sits directly upstream of the RAM and drives every RAM input.

## Interface
Parameters:
- DATA_W, 8, word width; must match RAM data width
- ADDR_W, 6, RAM address width; FIFO depth = 2**ADDR_W (64)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  push request
- wr_data  input  DATA_W  word to push
- full  output  1  FIFO holds 2**ADDR_W words
- rd_en  input  1  pop request
- rd_data  output  DATA_W  popped word, qualified by rd_valid
- rd_valid  output  1  one-cycle pulse, rd_data valid
- empty  output  1  FIFO holds 0 words
- count  output  ADDR_W+1  occupancy, 0..2**ADDR_W
- overflow  output  1  one-cycle pulse: wr_en while full
- underflow  output  1  one-cycle pulse: rd_en while empty
- ram_data_a  output  DATA_W  to RAM data_a
- ram_addr_a  output  ADDR_W  to RAM addr_a
- ram_we_a  output  1  to RAM we_a
- ram_data_b  output  DATA_W  to RAM data_b, tied 0
- ram_addr_b  output  ADDR_W  to RAM addr_b
- ram_we_b  output  1  to RAM we_b, tied 0
- ram_q_b  input  DATA_W  from RAM q_b

## Operation
- Single clock domain. Reset is asynchronous, active-low.
- Reset values:
  - wptr = rptr = 0, count = 0, empty = 1, full = 0.
  - rd_valid, overflow, underflow, ram_we_a = 0.
  - ram_addr_a = 0, ram_data_a = 0, rd_data = 0.
  - ram_addr_b = all-ones (2**ADDR_W-1), so that the first read, of address 0, changes addr_b and forces the level-sensitive RAM to re-evaluate q_b.
- Push accepted = wr_en & !full, with full sampled at the start of the cycle. Accepted push:
  - registers ram_addr_a = wptr, ram_data_a = wr_data, ram_we_a = 1 for exactly one cycle;
  - increments wptr modulo 2**ADDR_W.
- Pop accepted = rd_en & !empty, with empty sampled at the start of the cycle. Accepted pop:
  - registers ram_addr_b = rptr;
  - increments rptr modulo 2**ADDR_W.
- ram_addr_b holds its last value between pops. Consecutive pops always present a new address.
- Read capture: the cycle after ram_addr_b updates, rd_data <= ram_q_b and rd_valid = 1 for one cycle.
- count: +1 on an accepted push only, −1 on an accepted pop only, unchanged when both are accepted or neither is.
- Flags are registered and derived from the next count value:
  - empty = (count == 0)
  - full = (count == 2**ADDR_W)
- Rejected requests:
  - wr_en & full → push dropped; overflow pulses the next cycle; no state change.
  - rd_en & empty → pop dropped; underflow pulses the next cycle; no state change.
- Simultaneous push and pop:
  - When full: pop accepted, push rejected (overflow pulses); count becomes 2**ADDR_W−1.
  - When empty: push accepted, pop rejected (underflow pulses); count becomes 1.
  - Otherwise both are accepted.
- Pointer wrap: address 63 → 0 with no other side effect. Full versus empty is resolved only by count, never by pointer equality.
- Reset mid-operation:
  - All state returns to its reset values immediately, including any in-flight ram_we_a pulse (forced to 0).
  - RAM contents are not cleared but are treated as discarded.

## Timing
- Push at edge N → RAM write at N+1 (ram_we_a high for cycle N+1) → count and empty updated at N+1.
- Pop at edge N → ram_addr_b at N+1 → rd_data and rd_valid at N+2. Read latency is 2 cycles.
- Pop throughput is one per cycle; rd_valid pulses back-to-back for back-to-back pops.
- Earliest read of a word pushed at N:
  - pop accepted at N+1 (empty deasserted);
  - ram_addr_b at N+2, after that word's RAM write at N+1;
  - no read-during-write hazard.
- Flags, count, overflow and underflow are all registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then idle 3 cycles → empty = 1, full = 0, count = 0, ram_addr_b = 63, rd_valid never asserted.
- Push 0xA5 at cycle 1, pop at cycle 2 → ram_we_a at cycle 2 with addr 0 and data 0xA5; rd_valid at cycle 4 with rd_data = 0xA5; empty again after the pop.
- Push 64 words 0x00..0x3F back-to-back → full = 1 and count = 64 after the last push; a 65th push pulses overflow and leaves count at 64; 64 pops return 0x00..0x3F in order with wptr and rptr both wrapped to 0.
- Push and pop together while full, then push and pop together while empty → first case gives count 63 plus an overflow pulse; second case gives count 1 plus an underflow pulse; data order preserved.
- Wrap traffic: keep occupancy at 10 while streaming 200 words 0..199 → every popped value equals its push order, including across the 63 → 0 address boundary.
- Assert rst_n low mid-stream with count = 20 and a pop in flight → all outputs take reset values immediately and no rd_valid follows; after release the first push/pop pair returns the newly pushed word.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a 64x8 asynchronous dual-port RAM: port A writes, port B reads.
// Owns the pointers, the occupancy count and the status flags; every output is registered.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              we_a_q, we_a_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic push_acc;
  logic pop_acc;

  // Acceptance uses the registered flags, so a pop can free a slot only for the next cycle.
  assign push_acc = wr_en & ~full_q;
  assign pop_acc  = rd_en & ~empty_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    we_a_d     = push_acc;
    addr_a_d   = addr_a_q;
    data_a_d   = data_a_q;
    addr_b_d   = addr_b_q;
    rd_pend_d  = pop_acc;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_data_q;
    ovf_d      = wr_en & full_q;
    unf_d      = rd_en & empty_q;

    if (push_acc) begin
      addr_a_d = wptr_q;
      data_a_d = wr_data;
      wptr_d   = wptr_q + PTR_ONE;
    end
    if (pop_acc) begin
      addr_b_d = rptr_q;
      rptr_d   = rptr_q + PTR_ONE;
    end
    // RAM is asynchronous: q_b has settled one cycle after addr_b moved.
    if (rd_pend_q) begin
      rd_data_d = ram_q_b;
    end

    if (push_acc && !pop_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - CNT_ONE;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH);
  end

  // addr_b resets to all-ones so the very first read (address 0) is a real address change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      we_a_q     <= 1'b0;
      addr_a_q   <= '0;
      data_a_q   <= '0;
      addr_b_q   <= '1;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      we_a_q     <= we_a_d;
      addr_a_q   <= addr_a_d;
      data_a_q   <= data_a_d;
      addr_b_q   <= addr_b_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign ram_we_a   = we_a_q;
  assign ram_addr_a = addr_a_q;
  assign ram_data_a = data_a_q;
  assign ram_addr_b = addr_b_q;
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en;
  logic [7:0] wr_data;
  logic       full, empty, rd_valid, overflow, underflow;
  logic [7:0] rd_data;
  logic [6:0] count;
  logic [7:0] ram_data_a, ram_data_b, ram_q_b;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic       ram_we_a, ram_we_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b),
    .ram_q_b(ram_q_b)
  );

  // 64x8 RAM: write lands at the end of the cycle we_a is high, read is combinational.
  logic [7:0] mem [64];
  always @(posedge clk) if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
  assign ram_q_b = mem[ram_addr_b];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus running push/pop totals.
  logic [7:0] q[$];
  int         wcnt, rcnt;
  bit         pend_v;
  logic [7:0] pend_d;
  bit         e_we, e_valid, e_ovf, e_unf, e_empty, e_full;
  logic [5:0] e_addr_a, e_addr_b;
  logic [7:0] e_data_a, e_rd_data;
  int         e_count;

  task automatic model_reset();
    q.delete();
    wcnt = 0; rcnt = 0; pend_v = 0; pend_d = 0;
    e_we = 0; e_valid = 0; e_ovf = 0; e_unf = 0;
    e_empty = 1; e_full = 0; e_count = 0;
    e_addr_a = 0; e_data_a = 0; e_addr_b = 6'd63; e_rd_data = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit was_full, was_empty, push, pop;
      was_full  = (q.size() == 64);
      was_empty = (q.size() == 0);
      push = wr_en && !was_full;
      pop  = rd_en && !was_empty;
      e_valid = pend_v;
      if (pend_v) e_rd_data = pend_d;
      pend_v = pop;
      if (pop) begin
        pend_d   = q.pop_front();
        e_addr_b = 6'(rcnt % 64);
        rcnt++;
      end
      e_we = push;
      if (push) begin
        e_addr_a = 6'(wcnt % 64);
        e_data_a = wr_data;
        q.push_back(wr_data);
        wcnt++;
      end
      e_ovf   = wr_en && was_full;
      e_unf   = rd_en && was_empty;
      e_count = q.size();
      e_empty = (e_count == 0);
      e_full  = (e_count == 64);
    end
  end

  always @(posedge clk) begin
    #1;
    if (started && rst_n) begin
      chk("count",      32'(count),      32'(e_count));
      chk("empty",      32'(empty),      32'(e_empty));
      chk("full",       32'(full),       32'(e_full));
      chk("overflow",   32'(overflow),   32'(e_ovf));
      chk("underflow",  32'(underflow),  32'(e_unf));
      chk("rd_valid",   32'(rd_valid),   32'(e_valid));
      chk("ram_we_a",   32'(ram_we_a),   32'(e_we));
      chk("ram_addr_b", 32'(ram_addr_b), 32'(e_addr_b));
      chk("ram_we_b",   32'(ram_we_b),   32'h0);
      chk("ram_data_b", 32'(ram_data_b), 32'h0);
      if (e_we) begin
        chk("ram_addr_a", 32'(ram_addr_a), 32'(e_addr_a));
        chk("ram_data_a", 32'(ram_data_a), 32'(e_data_a));
      end
      if (e_valid) chk("rd_data", 32'(rd_data), 32'(e_rd_data));
    end
  end

  // Inputs change at the falling edge; returns at the next falling edge with outputs settled.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    wr_en = w; wr_data = d; rd_en = r;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; rd_en = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_count",  32'(count),      32'd0);
    chk("rst_empty",  32'(empty),      32'd1);
    chk("rst_full",   32'(full),       32'd0);
    chk("rst_addr_b", 32'(ram_addr_b), 32'd63);
    chk("rst_we_a",   32'(ram_we_a),   32'd0);
    chk("rst_addr_a", 32'(ram_addr_a), 32'd0);
    chk("rst_data_a", 32'(ram_data_a), 32'd0);
    chk("rst_rd_data",32'(rd_data),    32'd0);
    rst_n = 1'b1;
    started = 1;

    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0);
      chk("idle_rd_valid", 32'(rd_valid),   32'd0);
      chk("idle_addr_b",   32'(ram_addr_b), 32'd63);
      chk("idle_empty",    32'(empty),      32'd1);
    end

    step(1, 8'hA5, 0);
    chk("a5_we",     32'(ram_we_a),   32'd1);
    chk("a5_addr_a", 32'(ram_addr_a), 32'd0);
    chk("a5_data_a", 32'(ram_data_a), 32'hA5);
    chk("a5_count",  32'(count),      32'd1);
    step(0, 8'h00, 1);
    chk("a5_addr_b", 32'(ram_addr_b), 32'd0);
    chk("a5_empty",  32'(empty),      32'd1);
    chk("a5_valid0", 32'(rd_valid),   32'd0);
    step(0, 8'h00, 0);
    chk("a5_valid",  32'(rd_valid),   32'd1);
    chk("a5_rd",     32'(rd_data),    32'hA5);
    step(0, 8'h00, 0);
    chk("a5_valid_pulse", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 64; i++) step(1, 8'(i), 0);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd64);
    step(1, 8'hEE, 0);
    chk("ovf_pulse",  32'(overflow), 32'd1);
    chk("ovf_count",  32'(count),    32'd64);
    step(1, 8'h99, 1);
    chk("fullpp_ovf",   32'(overflow), 32'd1);
    chk("fullpp_count", 32'(count),    32'd63);
    chk("fullpp_full",  32'(full),     32'd0);
    for (int i = 0; i < 63; i++) step(0, 8'h00, 1);
    chk("drain_empty", 32'(empty), 32'd1);
    step(1, 8'h77, 1);
    chk("emptypp_unf",   32'(underflow), 32'd1);
    chk("emptypp_count", 32'(count),     32'd1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("pp_last_rd", 32'(rd_data), 32'h77);

    for (int i = 0; i < 10; i++) step(1, 8'(i), 0);
    for (int i = 10; i < 200; i++) step(1, 8'(i), 1);
    chk("stream_count", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("stream_last_rd", 32'(rd_data), 32'd199);

    for (int i = 0; i < 20; i++) step(1, 8'(100 + i), 0);
    step(0, 8'h00, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_count",  32'(count),      32'd0);
    chk("mrst_empty",  32'(empty),      32'd1);
    chk("mrst_full",   32'(full),       32'd0);
    chk("mrst_we_a",   32'(ram_we_a),   32'd0);
    chk("mrst_addr_b", 32'(ram_addr_b), 32'd63);
    chk("mrst_valid",  32'(rd_valid),   32'd0);
    chk("mrst_rd",     32'(rd_data),    32'd0);
    wr_en = 0; rd_en = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mrst_no_valid", 32'(rd_valid), 32'd0);
    end
    rst_n = 1'b1;
    step(1, 8'h5A, 0);
    chk("post_addr_a", 32'(ram_addr_a), 32'd0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("post_valid", 32'(rd_valid), 32'd1);
    chk("post_rd",    32'(rd_data),  32'h5A);

    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 300; i++)
        step($urandom_range(99) < 32'(pw), 8'($urandom), $urandom_range(99) < 32'(pr));
    end
    for (int i = 0; i < 70; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
